// File: rtl/line_pulse_generator_pkg.sv
// Shared types and helpers for the line pulse generator: state encoding,
// default widths and the zero-is-one clamp.
package line_pulse_generator_pkg;

  localparam int unsigned COUNT_W_DEF = 16;
  localparam int unsigned WIDTH_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  // A programmed phase length of zero behaves as a single cycle.
  function automatic logic [31:0] max1(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/line_phase_timer.sv
// Loadable down-counter timing one high or low phase; expired_c is high
// while the count sits at zero.
module line_phase_timer #(
  parameter int unsigned WIDTH_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH_W-1:0] load_val,
  output logic               expired_c
);

  logic [WIDTH_W-1:0] count_q;
  logic [WIDTH_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_c = (count_q == '0);

endmodule

// File: rtl/line_pulse_generator.sv
// Emits a programmed train of fixed-width pulses on a registered line output,
// with Busy, a one-cycle Done strobe and a count of completed pulses.
module line_pulse_generator
  import line_pulse_generator_pkg::*;
#(
  parameter int unsigned COUNT_W = COUNT_W_DEF,
  parameter int unsigned WIDTH_W = WIDTH_W_DEF
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Abort,
  input  logic [COUNT_W-1:0] PulseCount,
  input  logic [WIDTH_W-1:0] HighCycles,
  input  logic [WIDTH_W-1:0] LowCycles,
  output logic               LineOut,
  output logic               Busy,
  output logic               Done,
  output logic [COUNT_W-1:0] Sent
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] n_q, n_d;
  logic [WIDTH_W-1:0] h_q, h_d;
  logic [WIDTH_W-1:0] l_q, l_d;
  logic [COUNT_W-1:0] sent_q, sent_d;
  logic               line_q, line_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tmr_load;
  logic [WIDTH_W-1:0] tmr_val;
  logic               tmr_expired;

  line_phase_timer #(
    .WIDTH_W(WIDTH_W)
  ) u_timer (
    .clk      (CLK),
    .rst      (Reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired_c(tmr_expired)
  );

  // Next state, latched parameters and registered output values.
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    h_d      = h_q;
    l_d      = l_q;
    sent_d   = sent_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    case (state_q)
      ST_IDLE: begin
        if (Start && !Abort) begin
          sent_d = '0;
          if (PulseCount != '0) begin
            n_d      = PulseCount;
            h_d      = WIDTH_W'(max1(32'(HighCycles)));
            l_d      = WIDTH_W'(max1(32'(LowCycles)));
            tmr_load = 1'b1;
            tmr_val  = h_d - WIDTH_W'(1);
            state_d  = ST_HIGH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_HIGH: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          sent_d   = sent_q + COUNT_W'(1);
          tmr_load = 1'b1;
          tmr_val  = l_q - WIDTH_W'(1);
          state_d  = ST_LOW;
        end
      end
      ST_LOW: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          // Sent was already bumped on entry to LOW, so compare against N directly.
          if (sent_q == n_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = h_q - WIDTH_W'(1);
            state_d  = ST_HIGH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    line_d = (state_d == ST_HIGH);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      h_q     <= '0;
      l_q     <= '0;
      sent_q  <= '0;
      line_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      h_q     <= h_d;
      l_q     <= l_d;
      sent_q  <= sent_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign LineOut = line_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign Sent    = sent_q;

endmodule

// File: tb/tb_line_pulse_generator.sv
// Self-checking bench for line_pulse_generator against a cycle-indexed
// arithmetic model of the pulse train, plus a rising-edge counting receiver.
module tb_line_pulse_generator;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Abort;
  logic [15:0] PulseCount;
  logic [7:0]  HighCycles;
  logic [7:0]  LowCycles;
  logic        LineOut;
  logic        Busy;
  logic        Done;
  logic [15:0] Sent;

  int checks   = 0;
  int failures = 0;

  logic        rx_prev;
  logic [15:0] rx_cnt;

  line_pulse_generator dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .Start     (Start),
    .Abort     (Abort),
    .PulseCount(PulseCount),
    .HighCycles(HighCycles),
    .LowCycles (LowCycles),
    .LineOut   (LineOut),
    .Busy      (Busy),
    .Done      (Done),
    .Sent      (Sent)
  );

  always #5 CLK = ~CLK;

  // Line-counting receiver: counts rising edges of LineOut.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rx_prev <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      rx_prev <= LineOut;
      if (LineOut && !rx_prev) rx_cnt <= rx_cnt + 16'd1;
    end
  end

  // Expected {LineOut, Busy, Done, Sent} in cycle c (c >= 1) after Start was
  // sampled, for a train of n pulses with programmed high/low lengths h, l.
  function automatic logic [18:0] m_vec(input int c, input int n, input int h, input int l);
    int   hh;
    int   ll;
    int   p;
    int   t;
    int   s;
    logic ln;
    logic bz;
    logic dn;
    hh = (h == 0) ? 1 : h;
    ll = (l == 0) ? 1 : l;
    p  = hh + ll;
    t  = n * p;
    if (c >= 1 && c <= t) begin
      ln = ((c - 1) % p) < hh;
      bz = 1'b1;
      dn = 1'b0;
      s  = (c - 1) / p + ((((c - 1) % p) >= hh) ? 1 : 0);
    end else begin
      ln = 1'b0;
      bz = 1'b0;
      dn = (c == t + 1);
      s  = n;
    end
    return {ln, bz, dn, 16'(s)};
  endfunction

  function automatic logic [18:0] got_vec();
    return {LineOut, Busy, Done, Sent};
  endfunction

  task automatic start_train(input int n, input int h, input int l);
    @(negedge CLK);
    Start      = 1'b1;
    Abort      = 1'b0;
    PulseCount = 16'(n);
    HighCycles = 8'(h);
    LowCycles  = 8'(l);
  endtask

  task automatic test_reset();
    logic [18:0] g;
    Reset = 1'b1; Start = 1'b0; Abort = 1'b0;
    PulseCount = '0; HighCycles = '0; LowCycles = '0;
    @(negedge CLK);
    g = got_vec();
    checks++;
    if (g !== 19'd0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", g, 19'd0);
    end
    Reset = 1'b0;
    start_train(5, 2, 2);
    for (int c = 1; c <= 5; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 5, 2, 2)) begin
        failures++;
        $display("FAIL reset_pre c=%0d got=%h exp=%h", c, g, m_vec(c, 5, 2, 2));
      end
    end
    Reset = 1'b1;
    #1;
    g = got_vec();
    checks++;
    if (g !== 19'd0) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", g, 19'd0);
    end
    @(negedge CLK);
    Reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      g = got_vec();
      checks++;
      if (g !== 19'd0) begin
        failures++;
        $display("FAIL reset_after c=%0d got=%h exp=%h", c, g, 19'd0);
      end
    end
  endtask

  task automatic test_basic();
    logic [18:0] g;
    start_train(3, 2, 3);
    for (int c = 1; c <= 18; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 3, 2, 3)) begin
        failures++;
        $display("FAIL basic c=%0d got=%h exp=%h", c, g, m_vec(c, 3, 2, 3));
      end
    end
  endtask

  task automatic test_zero_clamp();
    logic [18:0] g;
    start_train(4, 0, 0);
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 4, 0, 0)) begin
        failures++;
        $display("FAIL zero_clamp c=%0d got=%h exp=%h", c, g, m_vec(c, 4, 0, 0));
      end
    end
  endtask

  task automatic test_zero_count();
    logic [18:0] g;
    start_train(0, 3, 3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 0, 3, 3)) begin
        failures++;
        $display("FAIL zero_count c=%0d got=%h exp=%h", c, g, m_vec(c, 0, 3, 3));
      end
    end
  endtask

  task automatic test_abort();
    logic [18:0] g;
    logic [18:0] e;
    start_train(10, 4, 4);
    for (int c = 1; c <= 26; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      e = (c <= 18) ? m_vec(c, 10, 4, 4) : {3'b000, 16'd2};
      g = got_vec();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL abort c=%0d got=%h exp=%h", c, g, e);
      end
      if (c == 18) Abort = 1'b1;
      if (c == 19) Abort = 1'b0;
    end
  endtask

  task automatic test_start_abort();
    logic [18:0] g;
    @(negedge CLK);
    Start = 1'b1; Abort = 1'b1;
    PulseCount = 16'd5; HighCycles = 8'd2; LowCycles = 8'd2;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        Start = 1'b0;
        Abort = 1'b0;
      end
      g = got_vec();
      checks++;
      if (g !== {3'b000, 16'd2}) begin
        failures++;
        $display("FAIL start_abort c=%0d got=%h exp=%h", c, g, {3'b000, 16'd2});
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [18:0] g;
    start_train(2, 3, 2);
    for (int c = 1; c <= 14; c++) begin
      @(negedge CLK);
      if (c == 1 || c == 4) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 2, 3, 2)) begin
        failures++;
        $display("FAIL start_busy c=%0d got=%h exp=%h", c, g, m_vec(c, 2, 3, 2));
      end
      if (c == 3) begin
        Start = 1'b1; PulseCount = 16'd99; HighCycles = 8'd7; LowCycles = 8'd1;
      end
    end
  endtask

  task automatic test_random();
    logic [18:0] g;
    int n;
    int h;
    int l;
    int t;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 6));
      h = int'($urandom_range(0, 5));
      l = int'($urandom_range(0, 5));
      t = n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l));
      start_train(n, h, l);
      for (int c = 1; c <= t + 3; c++) begin
        @(negedge CLK);
        g = got_vec();
        checks++;
        if (g !== m_vec(c, n, h, l)) begin
          failures++;
          $display("FAIL random k=%0d n=%0d h=%0d l=%0d c=%0d got=%h exp=%h",
                   k, n, h, l, c, g, m_vec(c, n, h, l));
        end
        // Scramble inputs while busy; stray Starts must be ignored.
        PulseCount = 16'($urandom);
        HighCycles = 8'($urandom);
        LowCycles  = 8'($urandom);
        Start      = (c < t) ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
    end
  endtask

  task automatic test_loopback();
    logic [18:0] g;
    logic [15:0] base;
    logic [15:0] delta;
    int bad = 0;
    base = rx_cnt;
    start_train(1000, 3, 5);
    for (int c = 1; c <= 8003; c++) begin
      @(negedge CLK);
      if (c == 1) Start = 1'b0;
      g = got_vec();
      checks++;
      if (g !== m_vec(c, 1000, 3, 5)) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL loopback c=%0d got=%h exp=%h", c, g, m_vec(c, 1000, 3, 5));
      end
    end
    delta = rx_cnt - base;
    checks++;
    if (delta !== 16'd1000) begin
      failures++;
      $display("FAIL loopback_rx got=%0d exp=%0d", delta, 1000);
    end
    checks++;
    if (Sent !== 16'd1000) begin
      failures++;
      $display("FAIL loopback_sent got=%0d exp=%0d", Sent, 1000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_clamp();
    test_zero_count();
    test_abort();
    test_start_abort();
    test_start_while_busy();
    test_random();
    test_loopback();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
